idli_iob_m: RTL and testbench

Parametrised I/O bridge between the idli core's word-wide data ports and the narrow nibble-serial `din`/`dout` pin handshakes of the top-level wrapper. The receive path assembles pin nibbles into words and buffers them in a FIFO. The transmit path buffers core words and serialises them onto the pins, LSB nibble first. Pin-side throughput is decoupled from the core in both directions. The block sits between the core and the pin wrapper, replacing the direct core-to-pin `din`/`dout` wiring.

---
 rtl/idli_iob_pkg.sv | 21 ++
 rtl/idli_iob_if.sv | 42 ++++
 rtl/idli_iob_fifo_m.sv | 54 +++++
 rtl/idli_iob_m.sv | 142 ++++++++++++++
 tb/tb_idli_iob_m.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/idli_iob_pkg.sv
// Shared constants, helper functions and serialiser state type for the idli I/O bridge.
package idli_iob_pkg;

    function automatic int f_nib(input int word_w, input int data_w);
        return word_w / data_w;
    endfunction

    function automatic int f_idx_w(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

    function automatic int f_lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/idli_iob_if.sv
// Handshake bundle of the idli I/O bridge: pin-side nibble ports, core-side word ports, FIFO levels.
interface idli_iob_if
    import idli_iob_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int WORD_W = 16,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = f_lvl_w(DEPTH);

    logic [DATA_W-1:0] i_iob_pin_din;
    logic              i_iob_pin_din_vld;
    logic              o_iob_pin_din_acp;
    logic [DATA_W-1:0] o_iob_pin_dout;
    logic              o_iob_pin_dout_vld;
    logic              i_iob_pin_dout_acp;
    logic [WORD_W-1:0] o_iob_core_din;
    logic              o_iob_core_din_vld;
    logic              i_iob_core_din_acp;
    logic [WORD_W-1:0] i_iob_core_dout;
    logic              i_iob_core_dout_vld;
    logic              o_iob_core_dout_acp;
    logic [LVL_W-1:0]  o_iob_rx_lvl;
    logic [LVL_W-1:0]  o_iob_tx_lvl;

    modport slave (
        input  i_iob_pin_din, i_iob_pin_din_vld, i_iob_pin_dout_acp,
        input  i_iob_core_din_acp, i_iob_core_dout, i_iob_core_dout_vld,
        output o_iob_pin_din_acp, o_iob_pin_dout, o_iob_pin_dout_vld,
        output o_iob_core_din, o_iob_core_din_vld, o_iob_core_dout_acp,
        output o_iob_rx_lvl, o_iob_tx_lvl
    );

    modport master (
        output i_iob_pin_din, i_iob_pin_din_vld, i_iob_pin_dout_acp,
        output i_iob_core_din_acp, i_iob_core_dout, i_iob_core_dout_vld,
        input  o_iob_pin_din_acp, o_iob_pin_dout, o_iob_pin_dout_vld,
        input  o_iob_core_din, o_iob_core_din_vld, o_iob_core_dout_acp,
        input  o_iob_rx_lvl, o_iob_tx_lvl
    );

endinterface

// File: rtl/idli_iob_fifo_m.sv
// Show-ahead FIFO with level counter; full always blocks a push, even alongside a pop.
module idli_iob_fifo_m
    import idli_iob_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_flush,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic [WIDTH-1:0]            i_data,
    output logic [WIDTH-1:0]            o_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [f_lvl_w(DEPTH)-1:0]   o_lvl
);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = f_lvl_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_lvl;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_lvl == LVL_W'(DEPTH));
    assign o_empty = (r_lvl == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_lvl   = r_lvl;
    // Head is masked while empty so stale entries never reach the output.
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_lvl    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_lvl <= r_lvl + 1'b1;
            else if (w_pop && !w_push) r_lvl <= r_lvl - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/idli_iob_m.sv
// idli I/O bridge: nibble assembler into an RX FIFO, TX FIFO drained by a nibble serialiser.
//  state | meaning
//  IDLE  | no word being sent; pops TX FIFO head as soon as it is non-empty
//  SHIFT | nibble r_tx_idx of current word on the pins, LSB nibble first
module idli_iob_m
    import idli_iob_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int WORD_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic       i_iob_gck,
    input  logic       i_iob_rst,
    input  logic       i_iob_flush,
    idli_iob_if.slave  io
);
    localparam int NIB   = f_nib(WORD_W, DATA_W);
    localparam int IDX_W = f_idx_w(NIB);
    localparam int LVL_W = f_lvl_w(DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    if (WORD_W % DATA_W != 0) begin : g_chk_div
        $error("idli_iob_m: WORD_W must be a multiple of DATA_W");
    end
    if (NIB < 2) begin : g_chk_nib
        $error("idli_iob_m: WORD_W must hold at least two DATA_W nibbles");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("idli_iob_m: DEPTH must be a power of two and at least 2");
    end

    logic              w_clr;
    logic              w_pin_din_acp;
    logic              w_core_dout_acp;
    logic [WORD_W-1:0] w_rx_word;
    logic              w_rx_push;
    logic              w_rx_pop;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic [WORD_W-1:0] w_rx_head;
    logic [LVL_W-1:0]  w_rx_lvl;
    logic              w_tx_push;
    logic              w_tx_pop;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic [WORD_W-1:0] w_tx_head;
    logic [LVL_W-1:0]  w_tx_lvl;
    logic              w_tx_last;

    logic [IDX_W-1:0]  r_rx_idx;
    logic [WORD_W-1:0] r_rx_word;
    ser_state_t        r_state;
    logic [IDX_W-1:0]  r_tx_idx;
    logic [WORD_W-1:0] r_tx_word;
    logic [DATA_W-1:0] r_pin_dout;
    logic              r_pin_dout_vld;

    assign w_clr           = i_iob_rst || i_iob_flush;
    assign w_pin_din_acp   = !w_clr && !((r_rx_idx == IDX_LAST) && w_rx_full);
    assign w_core_dout_acp = !w_clr && !w_tx_full;

    // Nibbles shift in from the top, so after NIB accepts nibble 0 sits in the low bits.
    assign w_rx_word = {io.i_iob_pin_din, r_rx_word[WORD_W-1:DATA_W]};
    assign w_rx_push = io.i_iob_pin_din_vld && w_pin_din_acp && (r_rx_idx == IDX_LAST);
    assign w_rx_pop  = io.i_iob_core_din_acp && !w_rx_empty && !w_clr;
    assign w_tx_push = io.i_iob_core_dout_vld && w_core_dout_acp;
    assign w_tx_last = (r_state == SHIFT) && io.i_iob_pin_dout_acp && (r_tx_idx == IDX_LAST);
    assign w_tx_pop  = !w_clr && !w_tx_empty && ((r_state == IDLE) || w_tx_last);

    always_ff @(posedge i_iob_gck) begin
        if (w_clr) begin
            r_rx_idx  <= '0;
            r_rx_word <= '0;
        end else if (io.i_iob_pin_din_vld && w_pin_din_acp) begin
            r_rx_word <= w_rx_word;
            r_rx_idx  <= (r_rx_idx == IDX_LAST) ? '0 : r_rx_idx + 1'b1;
        end
    end

    // A pop on the last accepted nibble reloads in place, keeping the pins busy without a bubble.
    always_ff @(posedge i_iob_gck) begin
        if (w_clr) begin
            r_state        <= IDLE;
            r_tx_idx       <= '0;
            r_tx_word      <= '0;
            r_pin_dout     <= '0;
            r_pin_dout_vld <= 1'b0;
        end else if (w_tx_pop) begin
            r_state        <= SHIFT;
            r_tx_idx       <= '0;
            r_tx_word      <= w_tx_head >> DATA_W;
            r_pin_dout     <= w_tx_head[DATA_W-1:0];
            r_pin_dout_vld <= 1'b1;
        end else if ((r_state == SHIFT) && io.i_iob_pin_dout_acp) begin
            if (r_tx_idx == IDX_LAST) begin
                r_state        <= IDLE;
                r_pin_dout     <= '0;
                r_pin_dout_vld <= 1'b0;
            end else begin
                r_tx_idx   <= r_tx_idx + 1'b1;
                r_tx_word  <= r_tx_word >> DATA_W;
                r_pin_dout <= r_tx_word[DATA_W-1:0];
            end
        end
    end

    idli_iob_fifo_m #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_rx_fifo (
        .i_clk   (i_iob_gck),
        .i_rst   (i_iob_rst),
        .i_flush (i_iob_flush),
        .i_push  (w_rx_push),
        .i_pop   (w_rx_pop),
        .i_data  (w_rx_word),
        .o_data  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_lvl   (w_rx_lvl)
    );

    idli_iob_fifo_m #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_tx_fifo (
        .i_clk   (i_iob_gck),
        .i_rst   (i_iob_rst),
        .i_flush (i_iob_flush),
        .i_push  (w_tx_push),
        .i_pop   (w_tx_pop),
        .i_data  (io.i_iob_core_dout),
        .o_data  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_lvl   (w_tx_lvl)
    );

    assign io.o_iob_pin_din_acp   = w_pin_din_acp;
    assign io.o_iob_pin_dout      = r_pin_dout;
    assign io.o_iob_pin_dout_vld  = r_pin_dout_vld;
    assign io.o_iob_core_din      = w_rx_head;
    assign io.o_iob_core_din_vld  = !w_rx_empty;
    assign io.o_iob_core_dout_acp = w_core_dout_acp;
    assign io.o_iob_rx_lvl        = w_rx_lvl;
    assign io.o_iob_tx_lvl        = w_tx_lvl;

endmodule

// File: tb/tb_idli_iob_m.sv
// Directed bench for idli_iob_m: RX assembly/backpressure, TX serialisation/stall, flush and reset.
module tb_idli_iob_m;
    localparam int DATA_W = 4;
    localparam int WORD_W = 16;
    localparam int DEPTH  = 4;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [15:0] drain_exp [4]  = '{16'h2222, 16'h3333, 16'h4444, 16'h5555};
    logic [3:0]  b2b_exp   [8]  = '{4'hF, 4'hE, 4'hE, 4'hB, 4'h4, 4'h3, 4'h2, 4'h1};
    logic        stall_acp [6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0]  stall_exp [6]  = '{4'h3, 4'hC, 4'h5, 4'h5, 4'h5, 4'hA};

    idli_iob_if #(.DATA_W(DATA_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) io ();

    idli_iob_m #(.DATA_W(DATA_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) u_dut (
        .i_iob_gck   (clk),
        .i_iob_rst   (rst),
        .i_iob_flush (flush),
        .io          (io)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_din_acp"},   32'(io.o_iob_pin_din_acp),   32'd0);
        chk({p, "_dout_acp"},  32'(io.o_iob_core_dout_acp), 32'd0);
        chk({p, "_din_vld"},   32'(io.o_iob_core_din_vld),  32'd0);
        chk({p, "_dout_vld"},  32'(io.o_iob_pin_dout_vld),  32'd0);
        chk({p, "_rx_lvl"},    32'(io.o_iob_rx_lvl),        32'd0);
        chk({p, "_tx_lvl"},    32'(io.o_iob_tx_lvl),        32'd0);
        chk({p, "_core_din"},  32'(io.o_iob_core_din),      32'd0);
        chk({p, "_pin_dout"},  32'(io.o_iob_pin_dout),      32'd0);
    endtask

    task automatic send_nib(input logic [3:0] n);
        int k = 0;
        io.i_iob_pin_din     = n;
        io.i_iob_pin_din_vld = 1'b1;
        #1;
        while (io.o_iob_pin_din_acp !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        if (k == 20) chk("din_acp_timeout", 32'(io.o_iob_pin_din_acp), 32'd1);
        tick();
        io.i_iob_pin_din_vld = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 0; i < 4; i++) send_nib(w[i*4 +: 4]);
    endtask

    initial begin
        io.i_iob_pin_din       = '0;
        io.i_iob_pin_din_vld   = 1'b0;
        io.i_iob_pin_dout_acp  = 1'b0;
        io.i_iob_core_din_acp  = 1'b0;
        io.i_iob_core_dout     = '0;
        io.i_iob_core_dout_vld = 1'b0;

        // reset values, then release
        tick();
        tick();
        chk_reset("rst1");
        rst = 1'b0;
        #1;
        chk("rel1_din_acp",  32'(io.o_iob_pin_din_acp),   32'd1);
        chk("rel1_dout_acp", 32'(io.o_iob_core_dout_acp), 32'd1);

        // RX assembly
        send_nib(4'h4);
        send_nib(4'h3);
        send_nib(4'h2);
        chk("rx_vld_early", 32'(io.o_iob_core_din_vld), 32'd0);
        send_nib(4'h1);
        chk("rx_word", 32'(io.o_iob_core_din),     32'h1234);
        chk("rx_vld",  32'(io.o_iob_core_din_vld), 32'd1);
        chk("rx_lvl",  32'(io.o_iob_rx_lvl),       32'd1);
        io.i_iob_core_din_acp = 1'b1;
        tick();
        io.i_iob_core_din_acp = 1'b0;
        chk("rx_lvl_pop", 32'(io.o_iob_rx_lvl), 32'd0);

        // RX backpressure
        send_word(16'h1111);
        send_word(16'h2222);
        send_word(16'h3333);
        send_word(16'h4444);
        send_nib(4'h5);
        send_nib(4'h5);
        send_nib(4'h5);
        io.i_iob_pin_din     = 4'h5;
        io.i_iob_pin_din_vld = 1'b1;
        #1;
        chk("bp_lvl",      32'(io.o_iob_rx_lvl),      32'd4);
        chk("bp_acp_low",  32'(io.o_iob_pin_din_acp), 32'd0);
        tick();
        chk("bp_acp_hold", 32'(io.o_iob_pin_din_acp), 32'd0);
        chk("bp_head",     32'(io.o_iob_core_din),    32'h1111);
        io.i_iob_core_din_acp = 1'b1;
        tick();
        io.i_iob_core_din_acp = 1'b0;
        chk("bp_acp_rise", 32'(io.o_iob_pin_din_acp), 32'd1);
        chk("bp_lvl_pop",  32'(io.o_iob_rx_lvl),      32'd3);
        tick();
        io.i_iob_pin_din_vld = 1'b0;
        chk("bp_lvl_refill", 32'(io.o_iob_rx_lvl), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_drain%0d", i), 32'(io.o_iob_core_din), 32'(drain_exp[i]));
            io.i_iob_core_din_acp = 1'b1;
            tick();
        end
        io.i_iob_core_din_acp = 1'b0;
        chk("bp_lvl_empty", 32'(io.o_iob_rx_lvl), 32'd0);

        // TX back-to-back
        io.i_iob_pin_dout_acp  = 1'b1;
        io.i_iob_core_dout     = 16'hBEEF;
        io.i_iob_core_dout_vld = 1'b1;
        chk("tx_core_acp", 32'(io.o_iob_core_dout_acp), 32'd1);
        tick();
        chk("tx_lvl_n1", 32'(io.o_iob_tx_lvl),       32'd1);
        chk("tx_vld_n1", 32'(io.o_iob_pin_dout_vld), 32'd0);
        io.i_iob_core_dout = 16'h1234;
        tick();
        io.i_iob_core_dout_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tx_b2b_vld%0d", i), 32'(io.o_iob_pin_dout_vld), 32'd1);
            chk($sformatf("tx_b2b_nib%0d", i), 32'(io.o_iob_pin_dout),     32'(b2b_exp[i]));
            tick();
        end
        chk("tx_b2b_end", 32'(io.o_iob_pin_dout_vld), 32'd0);
        chk("tx_b2b_lvl", 32'(io.o_iob_tx_lvl),       32'd0);

        // TX stall
        io.i_iob_pin_dout_acp  = 1'b0;
        io.i_iob_core_dout     = 16'hA5C3;
        io.i_iob_core_dout_vld = 1'b1;
        tick();
        io.i_iob_core_dout_vld = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            io.i_iob_pin_dout_acp = stall_acp[i];
            chk($sformatf("tx_stall_vld%0d", i), 32'(io.o_iob_pin_dout_vld), 32'd1);
            chk($sformatf("tx_stall_nib%0d", i), 32'(io.o_iob_pin_dout),     32'(stall_exp[i]));
            tick();
        end
        io.i_iob_pin_dout_acp = 1'b0;
        chk("tx_stall_end", 32'(io.o_iob_pin_dout_vld), 32'd0);

        // flush mid-operation
        send_nib(4'h1);
        send_nib(4'h2);
        io.i_iob_pin_dout_acp  = 1'b1;
        io.i_iob_core_dout     = 16'hCAFE;
        io.i_iob_core_dout_vld = 1'b1;
        tick();
        io.i_iob_core_dout_vld = 1'b0;
        tick();
        tick();
        tick();
        chk("fl_pre_nib", 32'(io.o_iob_pin_dout), 32'hA);
        flush                  = 1'b1;
        io.i_iob_pin_din       = 4'hF;
        io.i_iob_pin_din_vld   = 1'b1;
        io.i_iob_core_dout     = 16'h9999;
        io.i_iob_core_dout_vld = 1'b1;
        #1;
        chk("fl_din_acp",  32'(io.o_iob_pin_din_acp),   32'd0);
        chk("fl_dout_acp", 32'(io.o_iob_core_dout_acp), 32'd0);
        tick();
        flush                  = 1'b0;
        io.i_iob_pin_din_vld   = 1'b0;
        io.i_iob_core_dout_vld = 1'b0;
        io.i_iob_pin_dout_acp  = 1'b0;
        #1;
        chk("fl_rx_lvl",   32'(io.o_iob_rx_lvl),       32'd0);
        chk("fl_tx_lvl",   32'(io.o_iob_tx_lvl),       32'd0);
        chk("fl_dout_vld", 32'(io.o_iob_pin_dout_vld), 32'd0);
        chk("fl_din_vld",  32'(io.o_iob_core_din_vld), 32'd0);
        send_nib(4'h8);
        send_nib(4'h7);
        send_nib(4'h6);
        send_nib(4'h5);
        chk("fl_word", 32'(io.o_iob_core_din), 32'h5678);
        chk("fl_lvl",  32'(io.o_iob_rx_lvl),   32'd1);
        io.i_iob_core_din_acp = 1'b1;
        tick();
        io.i_iob_core_din_acp = 1'b0;

        // reset mid-operation with RX FIFO full
        send_word(16'h0F0F);
        send_word(16'h1E1E);
        send_word(16'h2D2D);
        send_word(16'h3C3C);
        chk("rs_full_lvl", 32'(io.o_iob_rx_lvl), 32'd4);
        rst = 1'b1;
        tick();
        chk_reset("rst2");
        rst = 1'b0;
        #1;
        chk("rel2_din_acp",  32'(io.o_iob_pin_din_acp),   32'd1);
        chk("rel2_dout_acp", 32'(io.o_iob_core_dout_acp), 32'd1);
        send_word(16'h9ABC);
        chk("rs_word", 32'(io.o_iob_core_din), 32'h9ABC);
        chk("rs_lvl",  32'(io.o_iob_rx_lvl),   32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
